// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: show-ahead mode selectors and the
// occupancy counter width, which must be able to represent a completely full FIFO.
package fifo_pkg;

    localparam int SHOWAHEAD_OFF = 32'sd0;
    localparam int SHOWAHEAD_ON  = 32'sd1;

    function automatic int usedw_width(input int addr_width);
        return addr_width + 32'sd1;
    endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read that hits the address being written in the same cycle returns the new word.
module ram_sdp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [(32'sd1 << ADDR_WIDTH)];

    // storage array: contents survive sclr
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // read register, write-first on address collision so a prefetch sees a same-edge write
    always_ff @(posedge clock) begin
        if (sclr) begin
            rd_data <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem_r[rd_addr];
            end
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Synchronous FIFO: pointers, occupancy counter, registered flags and error pulses,
// plus the show-ahead prefetch addressing in front of the ram_sdp storage.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 4,
    parameter int SHOWAHEAD        = SHOWAHEAD_OFF,
    parameter int ALMOST_FULL_LVL  = (32'sd1 << ADDR_WIDTH) - 32'sd2,
    parameter int ALMOST_EMPTY_LVL = 32'sd2
) (
    input  logic                                 clock,
    input  logic                                 sclr,
    input  logic [DATA_WIDTH-1:0]                data,
    input  logic                                 wrreq,
    input  logic                                 rdreq,
    output logic [DATA_WIDTH-1:0]                q,
    output logic                                 empty,
    output logic                                 full,
    output logic                                 almost_empty,
    output logic                                 almost_full,
    output logic [usedw_width(ADDR_WIDTH)-1:0]   usedw,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int UW = usedw_width(ADDR_WIDTH);
    localparam logic [UW-1:0]         DEPTH_C = UW'(32'sd1 << ADDR_WIDTH);
    localparam logic [UW-1:0]         AF_LVL  = UW'(ALMOST_FULL_LVL);
    localparam logic [UW-1:0]         AE_LVL  = UW'(ALMOST_EMPTY_LVL);
    localparam logic [UW-1:0]         CNT_ONE = UW'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1'b1);

    if ((ADDR_WIDTH < 32'sd1) || (ALMOST_EMPTY_LVL < 32'sd1) ||
        (ALMOST_EMPTY_LVL > ALMOST_FULL_LVL) ||
        (ALMOST_FULL_LVL > (32'sd1 << ADDR_WIDTH)) ||
        ((SHOWAHEAD != SHOWAHEAD_OFF) && (SHOWAHEAD != SHOWAHEAD_ON))) begin : g_bad_params
        $error("fifo_sync: illegal parameter combination");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
    logic [UW-1:0]         usedw_r;
    logic [UW-1:0]         usedw_nxt_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  ram_wr_en_s;
    logic                  ram_rd_en_s;
    logic [ADDR_WIDTH-1:0] ram_rd_addr_s;
    logic                  empty_r;
    logic                  full_r;
    logic                  almost_empty_r;
    logic                  almost_full_r;
    logic                  overflow_r;
    logic                  underflow_r;

    // acceptance, next pointers/count, and RAM read control
    always_comb begin
        wr_accept_s  = wrreq && !full_r;
        rd_accept_s  = rdreq && !empty_r;
        ram_wr_en_s  = wr_accept_s && !sclr;
        wr_ptr_nxt_s = wr_accept_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = rd_accept_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        case ({wr_accept_s, rd_accept_s})
            2'b10:   usedw_nxt_s = usedw_r + CNT_ONE;
            2'b01:   usedw_nxt_s = usedw_r - CNT_ONE;
            default: usedw_nxt_s = usedw_r;
        endcase
        // show-ahead keeps the read register loaded with the word at the next head
        if (SHOWAHEAD == SHOWAHEAD_ON) begin
            ram_rd_addr_s = rd_ptr_nxt_s;
            ram_rd_en_s   = (usedw_nxt_s != {UW{1'b0}});
        end else begin
            ram_rd_addr_s = rd_ptr_r;
            ram_rd_en_s   = rd_accept_s;
        end
    end

    // pointer, counter, flag and error-pulse registers
    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr_r       <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r       <= {ADDR_WIDTH{1'b0}};
            usedw_r        <= {UW{1'b0}};
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_empty_r <= 1'b1;
            almost_full_r  <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            usedw_r        <= usedw_nxt_s;
            empty_r        <= (usedw_nxt_s == {UW{1'b0}});
            full_r         <= (usedw_nxt_s == DEPTH_C);
            almost_empty_r <= (usedw_nxt_s < AE_LVL);
            almost_full_r  <= (usedw_nxt_s >= AF_LVL);
            overflow_r     <= wrreq && full_r;
            underflow_r    <= rdreq && empty_r;
        end
    end

    ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .sclr    (sclr),
        .wr_en   (ram_wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (data),
        .rd_en   (ram_rd_en_s),
        .rd_addr (ram_rd_addr_s),
        .rd_data (q)
    );

    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_empty = almost_empty_r;
    assign almost_full  = almost_full_r;
    assign usedw        = usedw_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: a normal-mode and a show-ahead instance share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_fifo_sync;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       sclr  = 1'b1;
    logic       wrreq = 1'b0;
    logic       rdreq = 1'b0;
    logic [7:0] data  = 8'h00;

    logic [7:0] q_n, q_s;
    logic       empty_n, full_n, ae_n, af_n, ovf_n, unf_n;
    logic       empty_s, full_s, ae_s, af_s, ovf_s, unf_s;
    logic [2:0] usedw_n, usedw_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] nq_exp = 8'h00;
    logic [7:0] sq_exp = 8'h00;
    logic       ovf_exp = 1'b0;
    logic       unf_exp = 1'b0;

    always #5 clock = ~clock;

    fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SHOWAHEAD(0),
                .ALMOST_FULL_LVL(3), .ALMOST_EMPTY_LVL(1)) dut_n (
        .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q_n), .empty(empty_n), .full(full_n), .almost_empty(ae_n),
        .almost_full(af_n), .usedw(usedw_n), .overflow(ovf_n), .underflow(unf_n));

    fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SHOWAHEAD(1),
                .ALMOST_FULL_LVL(3), .ALMOST_EMPTY_LVL(1)) dut_s (
        .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q_s), .empty(empty_s), .full(full_s), .almost_empty(ae_s),
        .almost_full(af_s), .usedw(usedw_s), .overflow(ovf_s), .underflow(unf_s));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: FIFO contents as a queue, updated with the inputs sampled at the edge
    task automatic model_edge();
        if (sclr) begin
            mq.delete();
            nq_exp  = 8'h00;
            sq_exp  = 8'h00;
            ovf_exp = 1'b0;
            unf_exp = 1'b0;
        end else begin
            bit was_full  = (mq.size() == DEPTH);
            bit was_empty = (mq.size() == 0);
            ovf_exp = wrreq && was_full;
            unf_exp = rdreq && was_empty;
            if (rdreq && !was_empty) nq_exp = mq.pop_front();
            if (wrreq && !was_full) mq.push_back(data);
            if (mq.size() > 0) sq_exp = mq[0];
        end
    endtask

    task automatic compare_all();
        int n = mq.size();
        chk("usedw_n", 32'(usedw_n), 32'(n));
        chk("usedw_s", 32'(usedw_s), 32'(n));
        chk("empty_n", 32'(empty_n), 32'(n == 0));
        chk("empty_s", 32'(empty_s), 32'(n == 0));
        chk("full_n",  32'(full_n),  32'(n == DEPTH));
        chk("full_s",  32'(full_s),  32'(n == DEPTH));
        chk("aempty_n", 32'(ae_n), 32'(n < 1));
        chk("aempty_s", 32'(ae_s), 32'(n < 1));
        chk("afull_n",  32'(af_n), 32'(n >= 3));
        chk("afull_s",  32'(af_s), 32'(n >= 3));
        chk("ovf_n", 32'(ovf_n), 32'(ovf_exp));
        chk("ovf_s", 32'(ovf_s), 32'(ovf_exp));
        chk("unf_n", 32'(unf_n), 32'(unf_exp));
        chk("unf_s", 32'(unf_s), 32'(unf_exp));
        chk("q_n", 32'(q_n), 32'(nq_exp));
        chk("q_s", 32'(q_s), 32'(sq_exp));
    endtask

    task automatic cyc(input logic s, input logic w, input logic r, input logic [7:0] d);
        sclr  = s;
        wrreq = w;
        rdreq = r;
        data  = d;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] wvals [4];
        logic [3:0] af_tab;
        wvals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        af_tab = 4'b1100;

        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_usedw", 32'(usedw_n), 32'd0);
        chk("rst_empty", 32'(empty_n), 32'd1);
        chk("rst_full",  32'(full_n),  32'd0);
        chk("rst_ae",    32'(ae_n),    32'd1);
        chk("rst_af",    32'(af_n),    32'd0);
        chk("rst_q_n",   32'(q_n),     32'd0);
        chk("rst_q_s",   32'(q_s),     32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // fill, checking the threshold flags at each level
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, wvals[i]);
            chk("fill_usedw", 32'(usedw_n), 32'(i + 1));
            chk("fill_ae",    32'(ae_n),    32'd0);
            chk("fill_af",    32'(af_n),    32'(af_tab[i]));
            chk("fill_q_s",   32'(q_s),     32'h11);
            chk("fill_q_n",   32'(q_n),     32'h00);
        end
        chk("fill_full", 32'(full_n), 32'd1);

        cyc(1'b0, 1'b1, 1'b0, 8'h55);
        chk("ovf_pulse", 32'(ovf_n),   32'd1);
        chk("ovf_usedw", 32'(usedw_n), 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_clear", 32'(ovf_n), 32'd0);

        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_q_n",   32'(q_n),     32'(wvals[i]));
            chk("drain_usedw", 32'(usedw_n), 32'(3 - i));
            if (i < 3) chk("drain_q_s", 32'(q_s), 32'(wvals[i + 1]));
        end
        chk("drain_empty", 32'(empty_n), 32'd1);

        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf_pulse", 32'(unf_n), 32'd1);
        chk("unf_q_n",   32'(q_n),   32'h44);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("unf_clear", 32'(unf_n), 32'd0);

        cyc(1'b0, 1'b1, 1'b0, 8'hA5);
        chk("sa_empty", 32'(empty_s), 32'd0);
        chk("sa_q",     32'(q_s),     32'hA5);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("sa_pop_empty", 32'(empty_s), 32'd1);
        chk("sa_pop_usedw", 32'(usedw_s), 32'd0);
        chk("sa_pop_q_n",   32'(q_n),     32'hA5);

        cyc(1'b0, 1'b1, 1'b1, 8'h3C);
        chk("both_empty_unf",   32'(unf_n),   32'd1);
        chk("both_empty_usedw", 32'(usedw_n), 32'd1);
        chk("both_empty_q_s",   32'(q_s),     32'h3C);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("both_empty_read", 32'(q_n), 32'h3C);

        cyc(1'b0, 1'b1, 1'b0, 8'h60);
        cyc(1'b0, 1'b1, 1'b0, 8'h61);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'(8'h62 + k));
            chk("simul_usedw", 32'(usedw_n), 32'd2);
            chk("simul_q_n",   32'(q_n),     32'(8'h60 + k));
        end

        cyc(1'b0, 1'b1, 1'b0, 8'h70);
        cyc(1'b0, 1'b1, 1'b0, 8'h71);
        cyc(1'b0, 1'b1, 1'b1, 8'h72);
        chk("both_full_ovf",   32'(ovf_n),   32'd1);
        chk("both_full_usedw", 32'(usedw_n), 32'd3);
        chk("both_full_q_n",   32'(q_n),     32'h6A);

        cyc(1'b1, 1'b1, 1'b0, 8'h99);
        chk("midrst_usedw", 32'(usedw_n), 32'd0);
        chk("midrst_empty", 32'(empty_n), 32'd1);
        chk("midrst_q_n",   32'(q_n),     32'd0);
        chk("midrst_q_s",   32'(q_s),     32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h5A);
        chk("midrst_q_s_new", 32'(q_s), 32'h5A);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("midrst_q_n_new", 32'(q_n), 32'h5A);

        // random traffic with shifting write/read bias and rare resets
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 1000; c++) begin
                logic w, r, s;
                w = ($urandom_range(99) < (30 + 20 * p));
                r = ($urandom_range(99) < (70 - 20 * p));
                s = ($urandom_range(299) == 0);
                cyc(s, w, r, 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
